// File: rtl/vmicro16_pkg.sv
// Shared bus definitions for vmicro16 Wishbone peripherals: widths, handshake
// state encoding and a counter-width helper.
package vmicro16_pkg;

    localparam int VM16_DATA_W = 16;
    localparam int VM16_ADDR_W = 16;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WAIT = 2'd1,
        WB_ACK  = 2'd2
    } wb_state_t;

    // Wait counter must hold WAIT_STATES itself; never narrower than one bit.
    function automatic int wb_cnt_width(input int wait_states);
        return (wait_states > 0) ? $clog2(wait_states + 1) : 1;
    endfunction

endpackage

// File: rtl/vmicro16_wb_slave_fsm.sv
// Reusable Wishbone classic responder handshake: request capture, optional
// wait states, abort on cyc drop, and a one-cycle registered ack.
module vmicro16_wb_slave_fsm
    import vmicro16_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_cyc,
    input  logic i_stb,
    output logic o_capture,
    output logic o_req_fire,
    output logic o_ack
);

    localparam int             CW      = wb_cnt_width(WAIT_STATES);
    localparam logic [CW-1:0]  LOAD    = CW'(WAIT_STATES);
    localparam bit             NO_WAIT = (WAIT_STATES == 0);

    wb_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_ack;
    logic            w_wait_done;

    assign o_capture   = (r_state == WB_IDLE) && i_cyc && i_stb;
    // A cyc drop on the final wait cycle still aborts: no ack for a dead cycle.
    assign w_wait_done = (r_state == WB_WAIT) && i_cyc && (r_cnt == CW'(1));
    assign o_req_fire  = (o_capture && NO_WAIT) || w_wait_done;
    assign o_ack       = r_ack;

    // NOTE: all state here updates with non-blocking assignments so every
    // register sees the pre-edge values of its neighbours, as hardware does.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WB_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= o_req_fire;
            case (r_state)
                WB_IDLE: begin
                    if (o_capture) begin
                        r_cnt   <= LOAD;
                        r_state <= NO_WAIT ? WB_ACK : WB_WAIT;
                    end
                end
                WB_WAIT: begin
                    if (!i_cyc) begin
                        r_state <= WB_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CW'(1)) begin
                        r_state <= WB_ACK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WB_ACK:  r_state <= WB_IDLE;
                default: r_state <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vmicro16_wb_regs.sv
// Wishbone classic register bank: 2^ADDR_BITS x 16-bit registers behind the
// shared responder handshake, with a registered read port.
module vmicro16_wb_regs
    import vmicro16_pkg::*;
#(
    parameter int ADDR_BITS   = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [VM16_ADDR_W-1:0] wb_addr_i,
    input  logic [VM16_DATA_W-1:0] wb_data_i,
    output logic [VM16_DATA_W-1:0] wb_data_o,
    output logic                   wb_ack_o
);

    localparam int NREGS = 1 << ADDR_BITS;

    logic [VM16_DATA_W-1:0] r_regs [NREGS];
    logic [ADDR_BITS-1:0]   r_idx;
    logic                   r_we;
    logic [VM16_DATA_W-1:0] r_wdata;
    logic [VM16_DATA_W-1:0] r_data;

    logic                   w_capture;
    logic                   w_fire;
    logic [ADDR_BITS-1:0]   w_idx;
    logic                   w_we;
    logic [VM16_DATA_W-1:0] w_wdata;
    logic                   w_unused_addr;

    vmicro16_wb_slave_fsm #(
        .WAIT_STATES (WAIT_STATES)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .i_cyc      (wb_cyc_i),
        .i_stb      (wb_stb_i),
        .o_capture  (w_capture),
        .o_req_fire (w_fire),
        .o_ack      (wb_ack_o)
    );

    // Upper address bits alias onto the bank.
    assign w_unused_addr = ^wb_addr_i[VM16_ADDR_W-1:ADDR_BITS];

    // With no wait states the commit lands on the capture edge itself.
    assign w_idx   = w_capture ? wb_addr_i[ADDR_BITS-1:0] : r_idx;
    assign w_we    = w_capture ? wb_we_i                  : r_we;
    assign w_wdata = w_capture ? wb_data_i                : r_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_capture) begin
            r_idx   <= wb_addr_i[ADDR_BITS-1:0];
            r_we    <= wb_we_i;
            r_wdata <= wb_data_i;
        end
    end

    // NOTE: the bank is cleared on reset, so it is flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_fire && w_we) begin
            r_regs[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_data <= '0;
        else       r_data <= (w_fire && !w_we) ? r_regs[w_idx] : '0;
    end

    assign wb_data_o = r_data;

endmodule
